stopwatch_lap_ctrl: RTL and testbench

- Control FSM that sequences the stopwatch counter datapath from front-panel buttons.
- Decodes start/stop, lap/reset and recall presses, drives the counter's run and clear controls, and chooses what time the LCD line shows.
- Keeps a small circular lap buffer. Sits between the 16-button input bus and the stopwatch counter / Digit_2_Seperator display path.

---
 rtl/stopwatch_lap_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_lap_ctrl
// Brief    : Button-driven stopwatch control FSM with a circular lap buffer.
//            Define LAP_SPLIT_DELTA_EN to store lap-to-lap deltas instead of
//            absolute lap times.
// Revision : 1.0
// ============================================================================
module stopwatch_lap_ctrl #(
  parameter int LAP_DEPTH = 4,
  parameter int HOLD_MS   = 2000,
  parameter int TIME_W    = 21
) (
  input  logic              clk_1kHz,
  input  logic              resetn,
  input  logic [15:0]       i_btns,
  input  logic [TIME_W-1:0] i_time,
  output logic              o_run,
  output logic              o_clear,
  output logic [TIME_W-1:0] o_disp_time,
  output logic [2:0]        o_state,
  output logic [4:0]        o_lap_cnt,
  output logic [4:0]        o_lap_sel
);

  localparam int PTR_W  = $clog2(LAP_DEPTH);
  localparam int HOLD_W = (HOLD_MS > 2) ? $clog2(HOLD_MS) : 1;
  localparam logic [HOLD_W-1:0] c_hold_load = HOLD_W'(HOLD_MS - 1);
  localparam logic [4:0]        c_lap_full  = 5'(LAP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_SPLIT   = 3'd2,
    S_STOPPED = 3'd3,
    S_RECALL  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_btn_q, r_btn_qq;
  logic [4:0]         r_lap_cnt, w_lap_cnt_nxt;
  logic [4:0]         r_lap_sel, w_lap_sel_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [TIME_W-1:0]  r_frozen, w_frozen_nxt;
  logic               r_clear, w_clear_nxt;
  logic               w_lap_we;
  logic [TIME_W-1:0]  w_lap_val;
  logic [TIME_W-1:0]  w_disp;
  logic [PTR_W-1:0]   w_rd_idx;
  logic [TIME_W-1:0]  r_laps [LAP_DEPTH];
  logic               w_ev_start, w_ev_lap, w_ev_recall;
  logic               w_unused_btns;

  assign w_unused_btns = ^i_btns[12:0];

  // Rising-edge detect on the two-stage button register: one event per press
  assign w_ev_start  = r_btn_q[2] & ~r_btn_qq[2];
  assign w_ev_lap    = r_btn_q[1] & ~r_btn_qq[1];
  assign w_ev_recall = r_btn_q[0] & ~r_btn_qq[0];

  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      r_btn_q  <= '0;
      r_btn_qq <= '0;
    end else begin
      r_btn_q  <= i_btns[15:13];
      r_btn_qq <= r_btn_q;
    end
  end

`ifdef LAP_SPLIT_DELTA_EN
  logic [TIME_W-1:0] r_prev_abs;

  function automatic logic [TIME_W-1:0] f_time_sub(input logic [TIME_W-1:0] a,
                                                   input logic [TIME_W-1:0] b);
    int cs, sec, mn;
    cs = int'(a[6:0]) - int'(b[6:0]);
    if (cs < 0) begin cs += 100; sec = -1; end else sec = 0;
    sec += int'(a[13:7]) - int'(b[13:7]);
    if (sec < 0) begin sec += 60; mn = -1; end else mn = 0;
    mn += int'(a[20:14]) - int'(b[20:14]);
    if (mn < 0) mn += 60;
    return {7'(mn), 7'(sec), 7'(cs)};
  endfunction

  assign w_lap_val = f_time_sub(i_time, r_prev_abs);

  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn)          r_prev_abs <= '0;
    else if (w_clear_nxt) r_prev_abs <= '0;
    else if (w_lap_we)    r_prev_abs <= i_time;
  end
`else
  assign w_lap_val = i_time;
`endif

  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lap_cnt_nxt = r_lap_cnt;
    w_lap_sel_nxt = r_lap_sel;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_hold_nxt    = r_hold;
    w_frozen_nxt  = r_frozen;
    w_clear_nxt   = 1'b0;
    w_lap_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ev_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_ev_start)    w_state_nxt = S_STOPPED;
        else if (w_ev_lap) w_lap_we    = 1'b1;
      end
      S_SPLIT: begin
        if (w_ev_start) begin
          w_state_nxt   = S_STOPPED;
          w_lap_sel_nxt = 5'd0;
        end else if (w_ev_lap) begin
          w_lap_we = 1'b1;
        end else if (r_hold == '0) begin
          w_state_nxt   = S_RUN;
          w_lap_sel_nxt = 5'd0;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      S_STOPPED: begin
        if (w_ev_start) begin
          w_state_nxt = S_RUN;
        end else if (w_ev_lap) begin
          w_state_nxt   = S_IDLE;
          w_clear_nxt   = 1'b1;
          w_lap_cnt_nxt = 5'd0;
          w_wr_ptr_nxt  = '0;
        end else if (w_ev_recall && (r_lap_cnt != 5'd0)) begin
          w_state_nxt   = S_RECALL;
          w_lap_sel_nxt = 5'd1;
        end
      end
      S_RECALL: begin
        if (w_ev_start) begin
          w_state_nxt   = S_RUN;
          w_lap_sel_nxt = 5'd0;
        end else if (w_ev_lap) begin
          w_state_nxt   = S_STOPPED;
          w_lap_sel_nxt = 5'd0;
        end else if (w_ev_recall) begin
          w_lap_sel_nxt = (r_lap_sel == r_lap_cnt) ? 5'd1 : r_lap_sel + 5'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_lap_sel_nxt = 5'd0;
        w_hold_nxt    = '0;
      end
    endcase

    // A full buffer keeps lap_cnt saturated while the pointer overwrites the oldest slot
    if (w_lap_we) begin
      w_state_nxt   = S_SPLIT;
      w_wr_ptr_nxt  = r_wr_ptr + 1'b1;
      w_lap_cnt_nxt = (r_lap_cnt == c_lap_full) ? r_lap_cnt : r_lap_cnt + 5'd1;
      w_frozen_nxt  = w_lap_val;
      w_hold_nxt    = c_hold_load;
      w_lap_sel_nxt = 5'd1;
    end
  end

  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      r_lap_cnt <= '0;
      r_lap_sel <= '0;
      r_wr_ptr  <= '0;
      r_hold    <= '0;
      r_frozen  <= '0;
      r_clear   <= 1'b0;
    end else begin
      r_lap_cnt <= w_lap_cnt_nxt;
      r_lap_sel <= w_lap_sel_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_frozen  <= w_frozen_nxt;
      r_clear   <= w_clear_nxt;
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (w_lap_we) r_laps[r_wr_ptr] <= w_lap_val;
  end

  assign w_rd_idx = r_wr_ptr - r_lap_sel[PTR_W-1:0];

  always_comb begin
    case (r_state)
      S_SPLIT:  w_disp = r_frozen;
      S_RECALL: w_disp = r_laps[w_rd_idx];
      default:  w_disp = i_time;
    endcase
  end

  // Live time passes straight through, so it is blanked while reset is held
  assign o_disp_time = resetn ? w_disp : '0;
  assign o_run       = (r_state == S_RUN) || (r_state == S_SPLIT);
  assign o_clear     = r_clear;
  assign o_state     = r_state;
  assign o_lap_cnt   = r_lap_cnt;
  assign o_lap_sel   = r_lap_sel;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_lap_ctrl
// Brief    : Self-checking bench for stopwatch_lap_ctrl (LAP_DEPTH=4, HOLD_MS=2000).
// Revision : 1.0
// ============================================================================
module tb_stopwatch_lap_ctrl;

  logic        clk_1kHz = 1'b0;
  logic        resetn   = 1'b1;
  logic [15:0] i_btns   = '0;
  logic [20:0] i_time   = '0;
  logic        o_run, o_clear;
  logic [20:0] o_disp_time;
  logic [2:0]  o_state;
  logic [4:0]  o_lap_cnt, o_lap_sel;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] exp_q[$];
  logic [20:0] lap_hist[$];
  int          model_cnt = 0;
`ifdef LAP_SPLIT_DELTA_EN
  logic [20:0] prev_abs = '0;
`endif

  stopwatch_lap_ctrl dut (
    .clk_1kHz    (clk_1kHz),
    .resetn      (resetn),
    .i_btns      (i_btns),
    .i_time      (i_time),
    .o_run       (o_run),
    .o_clear     (o_clear),
    .o_disp_time (o_disp_time),
    .o_state     (o_state),
    .o_lap_cnt   (o_lap_cnt),
    .o_lap_sel   (o_lap_sel)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  function automatic logic [20:0] mk(input int m, input int s, input int c);
    return {7'(m), 7'(s), 7'(c)};
  endfunction

`ifdef LAP_SPLIT_DELTA_EN
  // Reference delta via total centiseconds, wrapped at one hour
  function automatic logic [20:0] f_delta(input logic [20:0] t, input logic [20:0] p);
    int a, b, d;
    a = int'(t[20:14]) * 6000 + int'(t[13:7]) * 100 + int'(t[6:0]);
    b = int'(p[20:14]) * 6000 + int'(p[13:7]) * 100 + int'(p[6:0]);
    d = (a - b + 360000) % 360000;
    return mk(d / 6000, (d / 100) % 60, d % 100);
  endfunction
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1kHz);
    #1;
  endtask

  task automatic press(input int b);
    i_btns[b] = 1'b1;
    tick(1);
    i_btns[b] = 1'b0;
    tick(1);
  endtask

  task automatic model_clear();
    lap_hist.delete();
    model_cnt = 0;
`ifdef LAP_SPLIT_DELTA_EN
    prev_abs = '0;
`endif
  endtask

  // Drives a lap press and pushes the value the display should freeze at
  task automatic record_lap(input logic [20:0] t);
    logic [20:0] v;
    i_time = t;
`ifdef LAP_SPLIT_DELTA_EN
    v = f_delta(t, prev_abs);
    prev_abs = t;
`else
    v = t;
`endif
    exp_q.push_back(v);
    lap_hist.push_back(v);
    if (model_cnt < 4) model_cnt++;
    press(14);
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    #2 resetn = 1'b0;
    i_time = mk(1, 2, 3);
    tick(2);
    outs = {o_run, o_clear, o_state, o_lap_cnt, o_lap_sel, o_disp_time};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %0h want 0", outs); end
    resetn = 1'b1;
    model_clear();
    tick(1);
    n_cmp++; if (o_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_cmp++; if (o_disp_time !== mk(1, 2, 3)) begin n_bad++; $display("FAIL idle_live: got %0h want %0h", o_disp_time, mk(1, 2, 3)); end
  endtask

  task automatic test_start_stop();
    i_btns[15] = 1'b1;
    tick(1);
    n_cmp++; if (o_run !== 1'b0) begin n_bad++; $display("FAIL start_latency1: got %0b want 0", o_run); end
    i_btns[15] = 1'b0;
    tick(1);
    n_cmp++; if (o_run !== 1'b1) begin n_bad++; $display("FAIL start_run: got %0b want 1", o_run); end
    n_cmp++; if (o_state !== 3'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", o_state); end
    i_time = mk(0, 3, 45);
    #1;
    n_cmp++; if (o_disp_time !== mk(0, 3, 45)) begin n_bad++; $display("FAIL run_live: got %0h want %0h", o_disp_time, mk(0, 3, 45)); end
    i_time = mk(0, 3, 46);
    press(15);
    n_cmp++; if (o_state !== 3'd3) begin n_bad++; $display("FAIL stop_state: got %0d want 3", o_state); end
    n_cmp++; if (o_run !== 1'b0) begin n_bad++; $display("FAIL stop_run: got %0b want 0", o_run); end
    n_cmp++; if (o_disp_time !== mk(0, 3, 46)) begin n_bad++; $display("FAIL stop_live: got %0h want %0h", o_disp_time, mk(0, 3, 46)); end
  endtask

  task automatic test_lap_split();
    logic [20:0] e;
    press(15);
    record_lap(mk(0, 12, 34));
    e = exp_q.pop_front();
    n_cmp++; if (o_disp_time !== e) begin n_bad++; $display("FAIL split_disp: got %0h want %0h", o_disp_time, e); end
    n_cmp++; if (o_state !== 3'd2) begin n_bad++; $display("FAIL split_state: got %0d want 2", o_state); end
    n_cmp++; if ({o_run, o_lap_cnt, o_lap_sel} !== {1'b1, 5'd1, 5'd1}) begin
      n_bad++; $display("FAIL split_flags: got run=%0b cnt=%0d sel=%0d want 1/1/1", o_run, o_lap_cnt, o_lap_sel); end
    i_time = mk(0, 20, 0);
    tick(1998);
    n_cmp++; if (o_disp_time !== e) begin n_bad++; $display("FAIL split_frozen: got %0h want %0h", o_disp_time, e); end
    tick(1);
    n_cmp++; if (o_state !== 3'd2) begin n_bad++; $display("FAIL split_last: got %0d want 2", o_state); end
    tick(1);
    n_cmp++; if (o_state !== 3'd1) begin n_bad++; $display("FAIL split_exit: got %0d want 1", o_state); end
    n_cmp++; if (o_disp_time !== mk(0, 20, 0)) begin n_bad++; $display("FAIL split_live: got %0h want %0h", o_disp_time, mk(0, 20, 0)); end
    n_cmp++; if (o_lap_sel !== 5'd0) begin n_bad++; $display("FAIL split_sel: got %0d want 0", o_lap_sel); end
  endtask

  task automatic test_clear();
    press(15);
    n_cmp++; if (o_lap_cnt !== 5'(model_cnt)) begin n_bad++; $display("FAIL pre_clear_cnt: got %0d want %0d", o_lap_cnt, model_cnt); end
    i_btns[14] = 1'b1;
    tick(1);
    n_cmp++; if (o_clear !== 1'b0) begin n_bad++; $display("FAIL clear_early: got %0b want 0", o_clear); end
    i_btns[14] = 1'b0;
    tick(1);
    model_clear();
    n_cmp++; if ({o_clear, o_state, o_lap_cnt} !== {1'b1, 3'd0, 5'd0}) begin
      n_bad++; $display("FAIL clear_pulse: got clr=%0b st=%0d cnt=%0d want 1/0/0", o_clear, o_state, o_lap_cnt); end
    tick(1);
    n_cmp++; if (o_clear !== 1'b0) begin n_bad++; $display("FAIL clear_width: got %0b want 0", o_clear); end
    press(13);
    n_cmp++; if ({o_state, o_lap_sel} !== {3'd0, 5'd0}) begin
      n_bad++; $display("FAIL recall_ignored: got st=%0d sel=%0d want 0/0", o_state, o_lap_sel); end
  endtask

  task automatic test_laps_recall();
    logic [20:0] e;
    int sel;
    press(15);
    for (int i = 0; i < 6; i++) begin
      record_lap(mk(1, 10 + 3 * i, 7 * i + 5));
      e = exp_q.pop_front();
      n_cmp++; if (o_disp_time !== e) begin n_bad++; $display("FAIL lap%0d_disp: got %0h want %0h", i, o_disp_time, e); end
    end
    n_cmp++; if (o_lap_cnt !== 5'd4) begin n_bad++; $display("FAIL lap_sat: got %0d want 4", o_lap_cnt); end
    press(15);
    n_cmp++; if (o_state !== 3'd3) begin n_bad++; $display("FAIL split_stop: got %0d want 3", o_state); end
    sel = 0;
    for (int k = 0; k < 5; k++) begin
      sel = (sel == model_cnt) ? 1 : sel + 1;
      exp_q.push_back(lap_hist[lap_hist.size() - sel]);
      press(13);
      e = exp_q.pop_front();
      n_cmp++; if (o_lap_sel !== 5'(sel)) begin n_bad++; $display("FAIL recall%0d_sel: got %0d want %0d", k, o_lap_sel, sel); end
      n_cmp++; if (o_disp_time !== e) begin n_bad++; $display("FAIL recall%0d_disp: got %0h want %0h", k, o_disp_time, e); end
    end
  endtask

`ifdef LAP_SPLIT_DELTA_EN
  task automatic test_delta();
    logic [20:0] e;
    press(15);
    press(15);
    press(14);
    model_clear();
    press(15);
    record_lap(mk(0, 59, 95));
    e = exp_q.pop_front();
    n_cmp++; if (o_disp_time !== mk(0, 59, 95) || o_disp_time !== e) begin
      n_bad++; $display("FAIL delta1: got %0h want %0h", o_disp_time, mk(0, 59, 95)); end
    record_lap(mk(1, 0, 5));
    e = exp_q.pop_front();
    n_cmp++; if (o_disp_time !== mk(0, 0, 10) || o_disp_time !== e) begin
      n_bad++; $display("FAIL delta2: got %0h want %0h", o_disp_time, mk(0, 0, 10)); end
    press(15);
    press(13);
    n_cmp++; if (o_disp_time !== mk(0, 0, 10)) begin n_bad++; $display("FAIL delta_recall1: got %0h want %0h", o_disp_time, mk(0, 0, 10)); end
    press(13);
    n_cmp++; if (o_disp_time !== mk(0, 59, 95)) begin n_bad++; $display("FAIL delta_recall2: got %0h want %0h", o_disp_time, mk(0, 59, 95)); end
  endtask
`endif

  task automatic test_priority();
    press(15);
    n_cmp++; if ({o_state, o_lap_sel} !== {3'd1, 5'd0}) begin
      n_bad++; $display("FAIL recall_resume: got st=%0d sel=%0d want 1/0", o_state, o_lap_sel); end
    i_time = mk(3, 3, 3);
    i_btns[15] = 1'b1;
    i_btns[14] = 1'b1;
    tick(1);
    i_btns[15] = 1'b0;
    i_btns[14] = 1'b0;
    tick(1);
    n_cmp++; if ({o_state, o_lap_sel, o_lap_cnt} !== {3'd3, 5'd0, 5'(model_cnt)}) begin
      n_bad++; $display("FAIL prio_state: got st=%0d sel=%0d cnt=%0d want 3/0/%0d", o_state, o_lap_sel, o_lap_cnt, model_cnt); end
    n_cmp++; if (o_disp_time !== mk(3, 3, 3)) begin n_bad++; $display("FAIL prio_live: got %0h want %0h", o_disp_time, mk(3, 3, 3)); end
    i_btns[15] = 1'b1;
    tick(50);
    n_cmp++; if (o_state !== 3'd1) begin n_bad++; $display("FAIL hold_once: got %0d want 1", o_state); end
    i_btns[15] = 1'b0;
    tick(3);
    n_cmp++; if (o_state !== 3'd1) begin n_bad++; $display("FAIL hold_release: got %0d want 1", o_state); end
  endtask

  task automatic test_async_reset();
    logic [20:0] e;
    logic [35:0] outs;
    record_lap(mk(2, 0, 0));
    e = exp_q.pop_front();
    n_cmp++; if (o_disp_time !== e) begin n_bad++; $display("FAIL ar_split: got %0h want %0h", o_disp_time, e); end
    tick(5);
    #3 resetn = 1'b0;
    #1;
    outs = {o_run, o_clear, o_state, o_lap_cnt, o_lap_sel, o_disp_time};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL async_reset: got %0h want 0", outs); end
    tick(2);
    resetn = 1'b1;
    model_clear();
    tick(1);
    n_cmp++; if ({o_state, o_lap_cnt, o_run} !== {3'd0, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL post_reset: got st=%0d cnt=%0d run=%0b want 0/0/0", o_state, o_lap_cnt, o_run); end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_lap_split();
    test_clear();
    test_laps_recall();
`ifdef LAP_SPLIT_DELTA_EN
    test_delta();
`endif
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
